drive_cmd_sequencer: RTL

//  Upstream feeder for the two wheel servo PWM drivers (left/right motor_driver instances).

---
 rtl/drive_pkg.sv | 26 ++
 rtl/drive_cmd_sequencer_fifo.sv | 48 ++++
 rtl/drive_cmd_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/drive_pkg.sv
// Shared types for the wheel drive command path: motor instructions, packed command word, FSM state.
package drive_pkg;

  typedef enum logic [1:0] {
    INSTR_FWD  = 2'b01,
    INSTR_BACK = 2'b10,
    INSTR_STOP = 2'b11
  } instr_t;

  typedef struct packed {
    instr_t     left;
    instr_t     right;
    logic [3:0] dur;
  } drive_cmd_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // 2'b00 is not a valid driver instruction; treat it as STOP.
  function automatic instr_t remap_instr(input logic [1:0] raw);
    return (raw == 2'b00) ? INSTR_STOP : instr_t'(raw);
  endfunction

endpackage

// File: rtl/drive_cmd_sequencer_fifo.sv
// Synchronous FIFO for drive commands; circular pointers carry an extra wrap bit.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/drive_cmd_sequencer.sv
// Buffers packed drive commands and presents each one to the left/right wheel drivers for a timed number of PWM frames.
module drive_cmd_sequencer
  import drive_pkg::*;
#(
  parameter int FRAME_CYCLES = 3072,
  parameter int DUR_UNIT     = 10,
  parameter int DEPTH        = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_data,
  input  logic                   abort,
  output logic [1:0]             instr_l,
  output logic [1:0]             instr_r,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int FW = $clog2(FRAME_CYCLES);
  localparam int DW = $clog2(15 * DUR_UNIT + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
  localparam logic [DW-1:0] DUR_MULT   = DW'(DUR_UNIT);

  logic [FW-1:0] frame_cnt;
  logic          frame_tick;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop_req;
  logic [7:0]    fifo_dout;
  drive_cmd_t    head;

  state_t        state, state_nx;
  instr_t        il_q, il_nx;
  instr_t        ir_q, ir_nx;
  logic [DW-1:0] dur_q, dur_nx;

  assign frame_tick = (frame_cnt == FRAME_LAST);

  // Abort leaves the frame phase alone; only reset realigns it.
  always_ff @(posedge clk) begin
    if (reset || frame_tick) frame_cnt <= '0;
    else                     frame_cnt <= frame_cnt + FW'(1);
  end

  assign cmd_ready = !full && !abort && !reset;
  assign push      = cmd_valid && cmd_ready;
  assign head      = drive_cmd_t'(fifo_dout);

  cmd_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (abort),
    .push  (push),
    .pop   (pop_req && !abort),
    .din   (cmd_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // dur_q == 0 while in RUN marks a hold command that only yields to the next queued entry.
  always_comb begin
    state_nx = state;
    il_nx    = il_q;
    ir_nx    = ir_q;
    dur_nx   = dur_q;
    pop_req  = 1'b0;
    case (state)
      IDLE: pop_req = !empty;
      RUN: begin
        if (dur_q == '0) begin
          pop_req = !empty;
        end else if (frame_tick) begin
          if (dur_q == DW'(1)) begin
            if (!empty) begin
              pop_req = 1'b1;
            end else begin
              state_nx = IDLE;
              il_nx    = INSTR_STOP;
              ir_nx    = INSTR_STOP;
            end
          end else begin
            dur_nx = dur_q - DW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (pop_req) begin
      state_nx = RUN;
      il_nx    = remap_instr(head.left);
      ir_nx    = remap_instr(head.right);
      dur_nx   = DW'(head.dur) * DUR_MULT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state <= IDLE;
      il_q  <= INSTR_STOP;
      ir_q  <= INSTR_STOP;
      dur_q <= '0;
    end else begin
      state <= state_nx;
      il_q  <= il_nx;
      ir_q  <= ir_nx;
      dur_q <= dur_nx;
    end
  end

  assign instr_l = il_q;
  assign instr_r = ir_q;
  assign busy    = (state == RUN);

endmodule
